// File: rtl/lc3b_mem_arbiter.sv
// Merges the instruction-fetch port (A) and the data port (B) onto one physical
// memory port: registered grant FSM, data-port priority, fetch starvation guard.
module lc3b_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_a,
    input  logic [15:0] address_a,
    output logic        resp_a,
    output logic [15:0] rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [1:0]  pmem_wmask,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    input  logic        pmem_resp,
    input  logic [15:0] pmem_rdata
);

    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_A,
        SERVE_B
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_starve_inc;
    logic        r_pmem_read;
    logic        r_pmem_write;
    logic [1:0]  r_pmem_wmask;
    logic [15:0] r_pmem_address;
    logic [15:0] r_pmem_wdata;
    logic        w_req_a;
    logic        w_req_b;
    logic        w_grant_b;

    assign w_req_a = read_a;
    assign w_req_b = read_b | write_b;

    // B wins unless A is waiting and B has already taken STARVE_LIMIT grants in a row.
    assign w_grant_b    = w_req_b && (!w_req_a || (r_starve_cnt < LP_STARVE_LIMIT));
    assign w_starve_inc = (r_starve_cnt == 4'hF) ? r_starve_cnt : r_starve_cnt + 4'd1;

    // NOTE: next-state defaults to the current state first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_b) begin
                    w_state_next = SERVE_B;
                end else if (w_req_a) begin
                    w_state_next = SERVE_A;
                end
            end
            SERVE_A, SERVE_B: begin
                if (pmem_resp) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_starve_cnt   <= 4'd0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_wmask   <= 2'b00;
            r_pmem_address <= 16'h0000;
            r_pmem_wdata   <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_state_next == SERVE_B) begin
                        // Read and write together resolve to a write.
                        r_pmem_read    <= ~write_b;
                        r_pmem_write   <= write_b;
                        r_pmem_wmask   <= wmask_b;
                        r_pmem_address <= address_b;
                        r_pmem_wdata   <= wdata_b;
                        r_starve_cnt   <= w_req_a ? w_starve_inc : 4'd0;
                    end else if (w_state_next == SERVE_A) begin
                        r_pmem_read    <= 1'b1;
                        r_pmem_write   <= 1'b0;
                        r_pmem_wmask   <= 2'b11;
                        r_pmem_address <= address_a;
                        r_pmem_wdata   <= 16'h0000;
                        r_starve_cnt   <= 4'd0;
                    end
                end
                SERVE_A, SERVE_B: begin
                    if (pmem_resp) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: begin
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_wmask   = r_pmem_wmask;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    // Responses reach only the granted client; a stray pmem_resp in IDLE goes nowhere.
    assign resp_a  = (r_state == SERVE_A) && pmem_resp;
    assign resp_b  = (r_state == SERVE_B) && pmem_resp;
    assign rdata_a = (r_state == SERVE_A) ? pmem_rdata : 16'h0000;
    assign rdata_b = (r_state == SERVE_B) ? pmem_rdata : 16'h0000;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Scoreboard bench for lc3b_mem_arbiter: directed client traffic, a latency-programmable
// memory model, and a monitor that checks every physical access and response.
module tb_lc3b_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_a;
    logic [15:0] address_a;
    logic        resp_a;
    logic [15:0] rdata_a;
    logic        read_b;
    logic        write_b;
    logic [1:0]  wmask_b;
    logic [15:0] address_b;
    logic [15:0] wdata_b;
    logic        resp_b;
    logic [15:0] rdata_b;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          is_b;
        logic        rd;
        logic        wr;
        logic [1:0]  wmask;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } acc_t;

    acc_t sb_q[$];
    acc_t cur;
    bit   have_cur    = 1'b0;
    bit   prev_active = 1'b0;
    bit   active;

    int   mem_lat     = 3;
    int   mem_cnt     = 0;
    bit   inject_resp = 1'b0;

    lc3b_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .read_a       (read_a),
        .address_a    (address_a),
        .resp_a       (resp_a),
        .rdata_a      (rdata_a),
        .read_b       (read_b),
        .write_b      (write_b),
        .wmask_b      (wmask_b),
        .address_b    (address_b),
        .wdata_b      (wdata_b),
        .resp_b       (resp_b),
        .rdata_b      (rdata_b),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wmask   (pmem_wmask),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void expect_acc(input bit is_b, input logic rd, input logic wr,
                                       input logic [1:0] wmask, input logic [15:0] addr,
                                       input logic [15:0] wdata, input logic [15:0] rdata);
        acc_t a;
        a.is_b = is_b; a.rd = rd; a.wr = wr; a.wmask = wmask;
        a.addr = addr; a.wdata = wdata; a.rdata = rdata;
        sb_q.push_back(a);
    endfunction

    function automatic logic [15:0] mem_value(input logic [15:0] addr);
        return (addr == 16'h0040) ? 16'h1234 : ~addr;
    endfunction

    // Memory model: answers in the (mem_lat+1)-th cycle of a strobe, or on demand.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            pmem_resp  = 1'b0;
            pmem_rdata = 16'h0000;
            if (inject_resp) begin
                pmem_resp   = 1'b1;
                pmem_rdata  = 16'hDEAD;
                inject_resp = 1'b0;
                mem_cnt     = 0;
            end else if (pmem_read || pmem_write) begin
                mem_cnt++;
                if (mem_cnt > mem_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = pmem_read ? mem_value(pmem_address) : 16'h0000;
                    mem_cnt    = 0;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Monitor: pop on each new physical access, check holds and responses.
    initial begin
        forever begin
            @(negedge clk);
            active = pmem_read || pmem_write;
            if (active && !prev_active) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_grant", 64'(pmem_address), 64'hFFFF_FFFF);
                end else begin
                    cur      = sb_q.pop_front();
                    have_cur = 1'b1;
                    check("grant_kind", 64'({pmem_read, pmem_write, pmem_wmask}),
                          64'({cur.rd, cur.wr, cur.wmask}));
                    check("grant_addr", 64'(pmem_address), 64'(cur.addr));
                    if (cur.wr) check("grant_wdata", 64'(pmem_wdata), 64'(cur.wdata));
                    if (!cur.is_b) check("starve_cnt_after_a", 64'(dut.r_starve_cnt), 64'd0);
                end
            end else if (active && have_cur) begin
                check("pmem_hold", 64'({pmem_read, pmem_write, pmem_wmask, pmem_address}),
                      64'({cur.rd, cur.wr, cur.wmask, cur.addr}));
                if (cur.wr) check("pmem_hold_wdata", 64'(pmem_wdata), 64'(cur.wdata));
            end
            if (pmem_resp && active && have_cur) begin
                check("resp_steer", 64'({resp_a, resp_b}), 64'({!cur.is_b, cur.is_b}));
                if (cur.rd) check("rdata", 64'(cur.is_b ? rdata_b : rdata_a), 64'(cur.rdata));
                check("rdata_other_zero", 64'(cur.is_b ? rdata_a : rdata_b), 64'd0);
            end else begin
                check("no_resp", 64'({resp_a, resp_b}), 64'd0);
            end
            prev_active = active;
        end
    end

    task automatic wait_resp(input bit is_b);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = is_b ? resp_b : resp_a;
        end
        if (!seen) check(is_b ? "resp_b_timeout" : "resp_a_timeout", 64'd0, 64'd1);
    endtask

    // Client drivers: called just after a rising edge; return just after a rising edge.
    task automatic a_access(input logic [15:0] addr);
        read_a    = 1'b1;
        address_a = addr;
        wait_resp(1'b0);
        @(posedge clk);
        #1;
        read_a = 1'b0;
    endtask

    task automatic b_access(input logic rd, input logic wr, input logic [1:0] mask,
                            input logic [15:0] addr, input logic [15:0] wdata);
        read_b    = rd;
        write_b   = wr;
        wmask_b   = mask;
        address_b = addr;
        wdata_b   = wdata;
        wait_resp(1'b1);
        @(posedge clk);
        #1;
        read_b  = 1'b0;
        write_b = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; read_a = 1'b0; address_a = 16'h0000;
        read_b = 1'b0; write_b = 1'b0; wmask_b = 2'b00; address_b = 16'h0000; wdata_b = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_pmem", 64'({pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata}), 64'd0);
        check("reset_resp", 64'({resp_a, resp_b}), 64'd0);

        // Lone A read with 3-cycle memory latency.
        @(posedge clk);
        #1;
        expect_acc(1'b0, 1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000, 16'h1234);
        read_a    = 1'b1;
        address_a = 16'h0040;
        @(negedge clk);
        check("latency_not_yet", 64'(pmem_read), 64'd0);
        @(negedge clk);
        check("latency_strobe", 64'(pmem_read), 64'd1);
        wait_resp(1'b0);
        @(posedge clk);
        #1;
        read_a = 1'b0;
        @(negedge clk);
        check("back_to_idle", 64'({pmem_read, pmem_write}), 64'd0);

        // Simultaneous A and B: B first, then A after one idle cycle.
        @(posedge clk);
        #1;
        expect_acc(1'b1, 1'b0, 1'b1, 2'b01, 16'h2000, 16'hBEEF, 16'h0000);
        expect_acc(1'b0, 1'b1, 1'b0, 2'b11, 16'h0010, 16'h0000, 16'hFFEF);
        fork
            a_access(16'h0010);
            b_access(1'b0, 1'b1, 2'b01, 16'h2000, 16'hBEEF);
        join
        repeat (2) @(posedge clk);
        #1;

        // Starvation guard: order B, B, B, B, A, B.
        expect_acc(1'b1, 1'b1, 1'b0, 2'b11, 16'h4000, 16'h0000, 16'hBFFF);
        expect_acc(1'b1, 1'b1, 1'b0, 2'b11, 16'h4001, 16'h0000, 16'hBFFE);
        expect_acc(1'b1, 1'b1, 1'b0, 2'b11, 16'h4002, 16'h0000, 16'hBFFD);
        expect_acc(1'b1, 1'b1, 1'b0, 2'b11, 16'h4003, 16'h0000, 16'hBFFC);
        expect_acc(1'b0, 1'b1, 1'b0, 2'b11, 16'h0500, 16'h0000, 16'hFAFF);
        expect_acc(1'b1, 1'b1, 1'b0, 2'b11, 16'h4004, 16'h0000, 16'hBFFB);
        fork
            a_access(16'h0500);
            begin
                for (int i = 0; i < 5; i++) b_access(1'b1, 1'b0, 2'b11, 16'(16'h4000 + i), 16'h0000);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset while serving B; a late pmem_resp must be ignored.
        mem_lat = 20;
        expect_acc(1'b1, 1'b1, 1'b0, 2'b11, 16'h5000, 16'h0000, 16'h0000);
        read_b = 1'b1; address_b = 16'h5000; wmask_b = 2'b11;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_b = 1'b0;
        @(negedge clk);
        check("reset_mid_strobes", 64'({pmem_read, pmem_write}), 64'd0);
        @(posedge clk);
        #1;
        inject_resp = 1'b1;
        @(negedge clk);
        check("late_resp_present", 64'(pmem_resp), 64'd1);
        check("late_resp_ignored", 64'({resp_a, resp_b}), 64'd0);
        check("late_rdata_gated", 64'({rdata_a, rdata_b}), 64'd0);
        @(posedge clk);
        #1;
        mem_lat = 3;

        // Address change mid-access: latched address held, next access uses new one.
        expect_acc(1'b0, 1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000, 16'hFEFF);
        expect_acc(1'b0, 1'b1, 1'b0, 2'b11, 16'h0200, 16'h0000, 16'hFDFF);
        read_a = 1'b1; address_a = 16'h0100;
        @(posedge clk);
        #1;
        address_a = 16'h0200;
        wait_resp(1'b0);
        wait_resp(1'b0);
        @(posedge clk);
        #1;
        read_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Read and write both high on B resolve to a write.
        expect_acc(1'b1, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h55AA, 16'h0000);
        b_access(1'b1, 1'b1, 2'b11, 16'h3000, 16'h55AA);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Sits directly downstream of the pipelined CPU datapath's two memory ports.
- Merges port A (instruction fetch, read-only) and port B (MEM-stage data, read/write) onto the single physical memory port.
- Serializes accesses with a registered grant FSM, data-port priority and a starvation guard for fetch.
- Responses are steered back combinationally to the granted client only.

Parameters:
- STARVE_LIMIT, 4: consecutive B grants while A is pending before A is forced next (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- read_a  in  1  port A read request; held until resp_a
- address_a  in  16  port A word address
- resp_a  out  1  port A access complete
- rdata_a  out  16  port A read data, valid when resp_a
- read_b  in  1  port B read request; held until resp_b
- write_b  in  1  port B write request; held until resp_b
- wmask_b  in  2  port B byte mask (bit1 = high byte)
- address_b  in  16  port B address
- wdata_b  in  16  port B write data
- resp_b  out  1  port B access complete
- rdata_b  out  16  port B read data, valid when resp_b
- pmem_read  out  1  physical read strobe, registered
- pmem_write  out  1  physical write strobe, registered
- pmem_wmask  out  2  physical byte mask, registered
- pmem_address  out  16  physical address, registered
- pmem_wdata  out  16  physical write data, registered
- pmem_resp  in  1  physical access complete (single-cycle pulse)
- pmem_rdata  in  16  physical read data, valid with pmem_resp

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Both are fixed for this block.
- FSM states: IDLE, SERVE_A, SERVE_B.
- Reset effects:
  - state = IDLE, starve_cnt = 0.
  - All pmem_* registered outputs = 0.
  - resp_a = resp_b = 0.
  - Reset mid-access abandons the access; a late pmem_resp arriving in IDLE is ignored.
- Request definitions:
  - req_a = read_a.
  - req_b = read_b | write_b.
  - read_b and write_b both high is treated as a write.
- IDLE, choosing a grant:
  - If req_b and (!req_a or starve_cnt < STARVE_LIMIT): go to SERVE_B.
  - Else if req_a: go to SERVE_A.
  - Else: stay in IDLE.
- IDLE, on the grant edge:
  - Latch the client's address, wdata and wmask into the pmem_* registers.
  - Drive pmem_read / pmem_write from the request type.
  - For an A grant: pmem_wmask = 2'b11, pmem_write = 0.
- Arbitration latency: request seen in IDLE at cycle N -> pmem strobe high in cycle N+1.
- SERVE_x:
  - pmem_* held constant until pmem_resp.
  - resp_x = pmem_resp (combinational, gated by state).
  - rdata_x = pmem_rdata whenever state == SERVE_x; 0 otherwise.
  - On the pmem_resp edge: clear both strobes and return to IDLE.
- Minimum gap: one IDLE cycle between consecutive accesses. A back-to-back request is re-arbitrated in that cycle.
- starve_cnt (4 bits), updated on each grant edge:
  - B granted while req_a = 1: increment, saturating at 15.
  - A granted: clear to 0.
  - B granted while req_a = 0: clear to 0.
- Ungranted client: resp stays 0 and its request is only sampled in IDLE. Changes to its inputs during the other client's access are harmless.
- pmem_resp while in IDLE is ignored (no resp_a or resp_b pulse).
- Client address or data changes mid-access are ignored; the latched values are used.

Test Plan:
- Reset, then lone A read:
  - Stimulus: rst high 2 cycles; then read_a = 1, address_a = 16'h0040; memory responds 3 cycles after strobe with rdata = 16'h1234.
  - Required: pmem_read = 1 with pmem_address = 16'h0040 starting the cycle after the request; resp_a = 1 and rdata_a = 16'h1234 in the pmem_resp cycle; resp_b = 0 throughout; FSM back in IDLE on the next cycle.
- Simultaneous A and B:
  - Stimulus: read_a @ 16'h0010 and write_b @ 16'h2000 with wdata_b = 16'hBEEF, wmask_b = 2'b01, raised in the same cycle.
  - Required: B served first (pmem_write = 1, pmem_wmask = 2'b01, pmem_wdata = 16'hBEEF); then one IDLE cycle; then A read @ 16'h0010.
- Starvation guard:
  - Stimulus: read_a held high; B issues 5 back-to-back reads; STARVE_LIMIT = 4.
  - Required: grant order B, B, B, B, A, B; starve_cnt returns to 0 after the A grant.
- Reset mid-access:
  - Stimulus: assert rst while in SERVE_B; pmem_resp arrives 2 cycles later.
  - Required: pmem_read = pmem_write = 0 the cycle after rst; resp_b stays 0 and the late pmem_resp is ignored.
- Address change mid-access:
  - Stimulus: change address_a from 16'h0100 to 16'h0200 during SERVE_A.
  - Required: pmem_address stays 16'h0100 until pmem_resp; the next access uses 16'h0200.
- Read and write both high on port B:
  - Stimulus: read_b = write_b = 1 @ 16'h3000.
  - Required: pmem_write = 1 and pmem_read = 0.
